// File: rtl/core_bus_arbiter_pkg.sv
// core_bus_arbiter_pkg: shared types for the core-to-memory bus arbiter.
package core_bus_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;
   typedef enum logic [2:0] {MSIZE_1B, MSIZE_2B, MSIZE_4B, MSIZE_8B} msize_t;
   typedef struct packed {
      logic        is_write;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } mem_req_t;
   typedef struct packed {
      logic        ready;
      logic        valid;
      logic [63:0] data;
   } mem_resp_t;
   // Instruction words are 32-bit; addr[2] picks the half of the 64-bit beat.
   function automatic logic [31:0] ifetch_word(input logic [63:0] beat, input logic hi);
      return hi ? beat[63:32] : beat[31:0];
   endfunction
endpackage

// File: rtl/core_bus_arbiter_if.sv
// core_bus_arbiter_if: core-side ibus/dbus handshakes plus the shared memory-bus handshake.
interface core_bus_arbiter_if;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_addr_ok;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic [2:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_addr_ok;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;
   logic        mreq_valid;
   logic        mreq_is_write;
   logic [63:0] mreq_addr;
   logic [2:0]  mreq_size;
   logic [7:0]  mreq_strobe;
   logic [63:0] mreq_data;
   logic        mresp_ready;
   logic        mresp_valid;
   logic [63:0] mresp_data;
   modport slave (
      input  ireq_valid, ireq_addr, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
             mresp_ready, mresp_valid, mresp_data,
      output iresp_addr_ok, iresp_data_ok, iresp_data, dresp_addr_ok, dresp_data_ok, dresp_data,
             mreq_valid, mreq_is_write, mreq_addr, mreq_size, mreq_strobe, mreq_data
   );
   modport master (
      output ireq_valid, ireq_addr, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
             mresp_ready, mresp_valid, mresp_data,
      input  iresp_addr_ok, iresp_data_ok, iresp_data, dresp_addr_ok, dresp_data_ok, dresp_data,
             mreq_valid, mreq_is_write, mreq_addr, mreq_size, mreq_strobe, mreq_data
   );
endinterface

// File: rtl/core_bus_arbiter_arb_select.sv
// core_bus_arbiter_arb_select: picks the next bus owner from the two request valids,
// either dbus-first or alternating when both ask in the same cycle.
module core_bus_arbiter_arb_select
   import core_bus_arbiter_pkg::*;
#(
   parameter bit DBUS_FIRST = 1'b1
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   en,
   input  logic   ivalid,
   input  logic   dvalid,
   output logic   gnt_valid,
   output owner_t gnt
);
   owner_t ptr;
   assign gnt_valid = ivalid || dvalid;
   assign gnt = (dvalid && (!ivalid || DBUS_FIRST || ptr == OWN_D)) ? OWN_D : OWN_I;
   // Only a contested grant advances the pointer; a lone requester never disturbs it.
   always_ff @(posedge clk or negedge reset)
      if (!reset) ptr <= OWN_D;
      else if (en && ivalid && dvalid) ptr <= ptr == OWN_D ? OWN_I : OWN_D;
endmodule

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: serialises the core's ibus and dbus requests onto one memory bus,
// one transaction at a time, and returns each response to the requester that issued it.
module core_bus_arbiter
   import core_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT    = 1024,
   parameter int DBUS_FIRST = 1
) (
   input  logic              clk,
   input  logic              reset,
   core_bus_arbiter_if.slave bus,
   output logic              err_timeout
);
   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_REQ  = REQ;
   localparam logic [1:0] S_WAIT = WAIT;
   localparam logic [1:0] S_RESP = RESP;
   localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   logic [1:0]    state;
   owner_t        owner;
   owner_t        gnt;
   logic          gnt_valid;
   logic          done;
   mem_req_t      req_q;
   mem_req_t      dreq_s;
   mem_req_t      ireq_s;
   mem_resp_t     mresp;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   core_bus_arbiter_arb_select #(.DBUS_FIRST(DBUS_FIRST != 0)) u_sel (
      .clk(clk),
      .reset(reset),
      .en(state == S_IDLE),
      .ivalid(bus.ireq_valid),
      .dvalid(bus.dreq_valid),
      .gnt_valid(gnt_valid),
      .gnt(gnt)
   );
   assign mresp  = {bus.mresp_ready, bus.mresp_valid, bus.mresp_data};
   assign dreq_s = {|bus.dreq_strobe, bus.dreq_addr, bus.dreq_size, bus.dreq_strobe, bus.dreq_data};
   assign ireq_s = {1'b0, bus.ireq_addr, MSIZE_4B, 8'd0, 64'd0};
   // A beat accepted together with the request skips WAIT entirely.
   assign done   = (state == S_REQ && mresp.ready && mresp.valid) || (state == S_WAIT && mresp.valid);
   assign cnt_n  = cnt + CW'(1);
   assign {bus.mreq_is_write, bus.mreq_addr, bus.mreq_size, bus.mreq_strobe, bus.mreq_data} = req_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state             <= S_IDLE;
         owner             <= OWN_I;
         req_q             <= '0;
         bus.mreq_valid    <= 1'b0;
         bus.iresp_addr_ok <= 1'b0;
         bus.dresp_addr_ok <= 1'b0;
         bus.iresp_data_ok <= 1'b0;
         bus.dresp_data_ok <= 1'b0;
         bus.iresp_data    <= '0;
         bus.dresp_data    <= '0;
      end else begin
         bus.iresp_addr_ok <= 1'b0;
         bus.dresp_addr_ok <= 1'b0;
         bus.iresp_data_ok <= done && owner == OWN_I;
         bus.dresp_data_ok <= done && owner == OWN_D;
         if (done && owner == OWN_I) bus.iresp_data <= ifetch_word(mresp.data, req_q.addr[2]);
         if (done && owner == OWN_D) bus.dresp_data <= req_q.is_write ? 64'd0 : mresp.data;
         case (state)
            S_IDLE:
               if (gnt_valid) begin
                  owner             <= gnt;
                  req_q             <= gnt == OWN_D ? dreq_s : ireq_s;
                  bus.mreq_valid    <= 1'b1;
                  bus.iresp_addr_ok <= gnt == OWN_I;
                  bus.dresp_addr_ok <= gnt == OWN_D;
                  state             <= S_REQ;
               end
            S_REQ:
               if (mresp.ready) begin
                  bus.mreq_valid <= 1'b0;
                  state          <= mresp.valid ? S_RESP : S_WAIT;
               end
            S_WAIT:
               if (mresp.valid) state <= S_RESP;
            default:
               state <= S_IDLE;
         endcase
      end
   // The timeout only flags a stuck memory; the FSM keeps waiting regardless.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt         <= '0;
         err_timeout <= 1'b0;
      end else if (state == S_REQ || state == S_WAIT) begin
         if (cnt != CW'(TIMEOUT)) cnt <= cnt_n;
         if (TIMEOUT != 0 && cnt_n == CW'(TIMEOUT)) err_timeout <= 1'b1;
      end else begin
         cnt <= '0;
      end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed scenarios for the ibus/dbus arbiter, one task per feature.
module tb_core_bus_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic err0, err1;
   int   n_cmp = 0;
   int   n_bad = 0;
   core_bus_arbiter_if bus0 ();
   core_bus_arbiter_if bus1 ();
   core_bus_arbiter #(.TIMEOUT(1024), .DBUS_FIRST(1)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0), .err_timeout(err0));
   core_bus_arbiter #(.TIMEOUT(0), .DBUS_FIRST(0)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1), .err_timeout(err1));
   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_d(input logic v, input logic [63:0] a, input logic [2:0] s,
                          input logic [7:0] st, input logic [63:0] d);
      bus0.dreq_valid = v; bus0.dreq_addr = a; bus0.dreq_size = s;
      bus0.dreq_strobe = st; bus0.dreq_data = d;
   endtask

   task automatic mem(input logic r, input logic v, input logic [63:0] d);
      bus0.mresp_ready = r; bus0.mresp_valid = v; bus0.mresp_data = d;
   endtask

   task automatic test_reset;
      bus0.ireq_valid = 0; bus0.ireq_addr = '0; drive_d(0, '0, '0, '0, '0); mem(0, 0, '0);
      bus1.ireq_valid = 0; bus1.ireq_addr = '0; bus1.dreq_valid = 0; bus1.dreq_addr = '0;
      bus1.dreq_size = '0; bus1.dreq_strobe = '0; bus1.dreq_data = '0;
      bus1.mresp_ready = 0; bus1.mresp_valid = 0; bus1.mresp_data = '0;
      #1 reset = 0;
      #3;
      n_cmp++; if ({bus0.mreq_valid, bus0.iresp_addr_ok, bus0.dresp_addr_ok, bus0.iresp_data_ok, bus0.dresp_data_ok, err0} !== 6'b0) begin
         n_bad++; $display("FAIL reset_flags: got %b want 000000", {bus0.mreq_valid, bus0.iresp_addr_ok, bus0.dresp_addr_ok, bus0.iresp_data_ok, bus0.dresp_data_ok, err0}); end
      n_cmp++; if ({bus0.mreq_addr, bus0.mreq_data, bus0.mreq_strobe, bus0.mreq_size, bus0.mreq_is_write} !== '0) begin
         n_bad++; $display("FAIL reset_mreq: got addr %h data %h want 0", bus0.mreq_addr, bus0.mreq_data); end
      n_cmp++; if ({bus0.iresp_data, bus0.dresp_data} !== '0) begin
         n_bad++; $display("FAIL reset_resp: got %h %h want 0", bus0.iresp_data, bus0.dresp_data); end
      tick(2);
      reset = 1;
      tick();
      mem(0, 1, 64'h9999_9999_9999_9999);
      tick();
      n_cmp++; if ({bus0.iresp_data_ok, bus0.dresp_data_ok, bus0.mreq_valid} !== 3'b000) begin
         n_bad++; $display("FAIL idle_stray_valid: got %b want 000", {bus0.iresp_data_ok, bus0.dresp_data_ok, bus0.mreq_valid}); end
      mem(0, 0, '0);
      tick();
   endtask

   task automatic test_ifetch;
      bus0.ireq_valid = 1; bus0.ireq_addr = 64'h8000_0004;
      tick();
      bus0.ireq_valid = 0;
      n_cmp++; if ({bus0.iresp_addr_ok, bus0.dresp_addr_ok, bus0.mreq_valid, bus0.mreq_is_write} !== 4'b1010) begin
         n_bad++; $display("FAIL if_grant: got %b want 1010", {bus0.iresp_addr_ok, bus0.dresp_addr_ok, bus0.mreq_valid, bus0.mreq_is_write}); end
      n_cmp++; if ({bus0.mreq_addr, bus0.mreq_size, bus0.mreq_strobe} !== {64'h8000_0004, 3'd2, 8'h00}) begin
         n_bad++; $display("FAIL if_mreq: got addr %h size %0d strobe %h want 80000004 2 00", bus0.mreq_addr, bus0.mreq_size, bus0.mreq_strobe); end
      mem(1, 0, '0);
      tick();
      mem(0, 0, '0);
      n_cmp++; if ({bus0.mreq_valid, bus0.iresp_addr_ok} !== 2'b00) begin
         n_bad++; $display("FAIL if_accept: got %b want 00", {bus0.mreq_valid, bus0.iresp_addr_ok}); end
      tick();
      mem(0, 1, 64'h1111_2222_3333_4444);
      tick();
      mem(0, 0, '0);
      n_cmp++; if ({bus0.iresp_data_ok, bus0.dresp_data_ok} !== 2'b10) begin
         n_bad++; $display("FAIL if_data_ok: got %b want 10", {bus0.iresp_data_ok, bus0.dresp_data_ok}); end
      n_cmp++; if (bus0.iresp_data !== 32'h1111_2222) begin
         n_bad++; $display("FAIL if_data: got %h want 11112222", bus0.iresp_data); end
      tick();
      n_cmp++; if (bus0.iresp_data_ok !== 1'b0) begin
         n_bad++; $display("FAIL if_pulse_once: got %b want 0", bus0.iresp_data_ok); end
   endtask

   task automatic test_priority;
      drive_d(1, 64'h8000_1000, 3'd3, 8'h00, '0);
      bus0.ireq_valid = 1; bus0.ireq_addr = 64'h8000_0010;
      tick();
      bus0.dreq_valid = 0;
      n_cmp++; if ({bus0.dresp_addr_ok, bus0.iresp_addr_ok} !== 2'b10) begin
         n_bad++; $display("FAIL pri_grant: got %b want 10", {bus0.dresp_addr_ok, bus0.iresp_addr_ok}); end
      n_cmp++; if ({bus0.mreq_addr, bus0.mreq_size, bus0.mreq_is_write} !== {64'h8000_1000, 3'd3, 1'b0}) begin
         n_bad++; $display("FAIL pri_mreq: got %h %0d %b want 80001000 3 0", bus0.mreq_addr, bus0.mreq_size, bus0.mreq_is_write); end
      mem(1, 1, 64'hDEAD_BEEF_0123_4567);
      tick();
      mem(0, 0, '0);
      n_cmp++; if ({bus0.dresp_data_ok, bus0.iresp_data_ok, bus0.mreq_valid} !== 3'b100) begin
         n_bad++; $display("FAIL pri_d_resp: got %b want 100", {bus0.dresp_data_ok, bus0.iresp_data_ok, bus0.mreq_valid}); end
      n_cmp++; if (bus0.dresp_data !== 64'hDEAD_BEEF_0123_4567) begin
         n_bad++; $display("FAIL pri_d_data: got %h want deadbeef01234567", bus0.dresp_data); end
      tick();
      n_cmp++; if ({bus0.mreq_valid, bus0.iresp_addr_ok, bus0.dresp_data_ok} !== 3'b000) begin
         n_bad++; $display("FAIL pri_gap: got %b want 000", {bus0.mreq_valid, bus0.iresp_addr_ok, bus0.dresp_data_ok}); end
      tick();
      bus0.ireq_valid = 0;
      n_cmp++; if ({bus0.iresp_addr_ok, bus0.mreq_valid, bus0.mreq_addr, bus0.mreq_size} !== {2'b11, 64'h8000_0010, 3'd2}) begin
         n_bad++; $display("FAIL pri_i_grant: got %b%b %h %0d want 11 80000010 2", bus0.iresp_addr_ok, bus0.mreq_valid, bus0.mreq_addr, bus0.mreq_size); end
      mem(1, 1, 64'hCAFE_F00D_89AB_CDEF);
      tick();
      mem(0, 0, '0);
      n_cmp++; if ({bus0.iresp_data_ok, bus0.dresp_data_ok, bus0.iresp_data} !== {2'b10, 32'h89AB_CDEF}) begin
         n_bad++; $display("FAIL pri_i_resp: got %b%b %h want 10 89abcdef", bus0.iresp_data_ok, bus0.dresp_data_ok, bus0.iresp_data); end
      tick();
   endtask

   task automatic test_write;
      drive_d(1, 64'h8000_2008, 3'd2, 8'h0F, 64'hAABB_CCDD);
      tick();
      drive_d(0, '0, '0, '0, '0);
      n_cmp++; if ({bus0.dresp_addr_ok, bus0.mreq_valid, bus0.mreq_is_write} !== 3'b111) begin
         n_bad++; $display("FAIL wr_grant: got %b want 111", {bus0.dresp_addr_ok, bus0.mreq_valid, bus0.mreq_is_write}); end
      n_cmp++; if ({bus0.mreq_addr, bus0.mreq_size, bus0.mreq_strobe, bus0.mreq_data} !== {64'h8000_2008, 3'd2, 8'h0F, 64'hAABB_CCDD}) begin
         n_bad++; $display("FAIL wr_mreq: got %h %0d %h %h want 80002008 2 0f aabbccdd", bus0.mreq_addr, bus0.mreq_size, bus0.mreq_strobe, bus0.mreq_data); end
      tick();
      n_cmp++; if ({bus0.mreq_valid, bus0.dresp_addr_ok, bus0.mreq_strobe, bus0.mreq_data} !== {2'b10, 8'h0F, 64'hAABB_CCDD}) begin
         n_bad++; $display("FAIL wr_hold: got %b%b %h %h want 10 0f aabbccdd", bus0.mreq_valid, bus0.dresp_addr_ok, bus0.mreq_strobe, bus0.mreq_data); end
      mem(1, 0, '0);
      tick();
      mem(0, 1, 64'h5555_6666_7777_8888);
      n_cmp++; if (bus0.mreq_valid !== 1'b0) begin
         n_bad++; $display("FAIL wr_drop: got %b want 0", bus0.mreq_valid); end
      tick();
      mem(0, 0, '0);
      n_cmp++; if ({bus0.dresp_data_ok, bus0.iresp_data_ok, bus0.dresp_data} !== {2'b10, 64'h0}) begin
         n_bad++; $display("FAIL wr_resp: got %b%b %h want 10 0", bus0.dresp_data_ok, bus0.iresp_data_ok, bus0.dresp_data); end
      tick();
   endtask

   task automatic test_alternate;
      logic [3:0] got = '0;
      int g = 0;
      bus1.ireq_valid = 1; bus1.ireq_addr = 64'h8000_0100;
      bus1.dreq_valid = 1; bus1.dreq_addr = 64'h8000_0200; bus1.dreq_size = 3'd3;
      bus1.mresp_ready = 1; bus1.mresp_valid = 1; bus1.mresp_data = 64'h0123;
      for (int c = 0; c < 40 && g < 4; c++) begin
         tick();
         if (bus1.dresp_addr_ok || bus1.iresp_addr_ok) begin
            got[g] = bus1.dresp_addr_ok;
            g++;
         end
      end
      bus1.ireq_valid = 0; bus1.dreq_valid = 0; bus1.mresp_ready = 0; bus1.mresp_valid = 0;
      tick(3);
      n_cmp++; if (g != 4) begin
         n_bad++; $display("FAIL alt_count: got %0d grants want 4", g); end
      n_cmp++; if (got !== 4'b0101) begin
         n_bad++; $display("FAIL alt_order: got %b want 0101 (D,I,D,I from bit0)", got); end
   endtask

   task automatic test_timeout;
      bus0.ireq_valid = 1; bus0.ireq_addr = 64'h8000_0020;
      tick();
      bus0.ireq_valid = 0;
      tick(1023);
      n_cmp++; if (err0 !== 1'b0) begin
         n_bad++; $display("FAIL to_early: got %b want 0", err0); end
      tick();
      n_cmp++; if (err0 !== 1'b1) begin
         n_bad++; $display("FAIL to_rise: got %b want 1", err0); end
      tick(76);
      n_cmp++; if (bus0.mreq_valid !== 1'b1) begin
         n_bad++; $display("FAIL to_still_waiting: got %b want 1", bus0.mreq_valid); end
      mem(1, 1, 64'h0000_0001_7777_8888);
      tick();
      mem(0, 0, '0);
      n_cmp++; if ({bus0.iresp_data_ok, bus0.iresp_data, err0} !== {1'b1, 32'h7777_8888, 1'b1}) begin
         n_bad++; $display("FAIL to_complete: got %b %h %b want 1 77778888 1", bus0.iresp_data_ok, bus0.iresp_data, err0); end
      tick(2);
      n_cmp++; if (err0 !== 1'b1) begin
         n_bad++; $display("FAIL to_sticky: got %b want 1", err0); end
   endtask

   task automatic test_reset_mid;
      drive_d(1, 64'h8000_3000, 3'd3, 8'h00, '0);
      tick();
      drive_d(0, '0, '0, '0, '0);
      mem(1, 0, '0);
      tick();
      mem(0, 0, '0);
      #2 reset = 0;
      #1;
      n_cmp++; if ({bus0.mreq_valid, bus0.dresp_addr_ok, bus0.dresp_data_ok, err0, bus0.mreq_addr, bus0.dresp_data} !== '0) begin
         n_bad++; $display("FAIL rst_mid_outputs: got %b%b%b%b %h %h want all 0", bus0.mreq_valid, bus0.dresp_addr_ok, bus0.dresp_data_ok, err0, bus0.mreq_addr, bus0.dresp_data); end
      tick();
      reset = 1;
      mem(0, 1, 64'hFFFF_0000_FFFF_0000);
      tick();
      mem(0, 0, '0);
      n_cmp++; if ({bus0.iresp_data_ok, bus0.dresp_data_ok} !== 2'b00) begin
         n_bad++; $display("FAIL rst_no_data_ok: got %b want 00", {bus0.iresp_data_ok, bus0.dresp_data_ok}); end
      tick();
      drive_d(1, 64'h8000_4000, 3'd3, 8'h00, '0);
      tick();
      drive_d(0, '0, '0, '0, '0);
      n_cmp++; if ({bus0.dresp_addr_ok, bus0.mreq_valid, bus0.mreq_addr} !== {2'b11, 64'h8000_4000}) begin
         n_bad++; $display("FAIL rst_next_grant: got %b%b %h want 11 80004000", bus0.dresp_addr_ok, bus0.mreq_valid, bus0.mreq_addr); end
      mem(1, 1, 64'h0BAD_F00D_1234_5678);
      tick();
      mem(0, 0, '0);
      n_cmp++; if ({bus0.dresp_data_ok, bus0.dresp_data} !== {1'b1, 64'h0BAD_F00D_1234_5678}) begin
         n_bad++; $display("FAIL rst_next_resp: got %b %h want 1 0badf00d12345678", bus0.dresp_data_ok, bus0.dresp_data); end
      tick();
   endtask

   initial begin
      test_reset();
      test_ifetch();
      test_priority();
      test_write();
      test_alternate();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
